// File: rtl/ledpanel_pkg.sv
// Shared types and constants for the LED panel byte-stream loader.
// The header is SEL, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, followed by RGB pixel triples.
package ledpanel_pkg;
  localparam int HDR_LEN    = 5;
  localparam int ADDR_W_DEF = 16;
  localparam int WR_W_DEF   = 4;

  typedef enum logic [3:0] {
    HDR_SEL,
    HDR_AH,
    HDR_AL,
    HDR_NH,
    HDR_NL,
    PIX_R,
    PIX_G,
    PIX_B,
    DRAIN
  } state_t;
endpackage

// File: rtl/ledpanel_loader.sv
// Parses a framed byte stream into one-cycle pixel writes for the ledpanel
// colour memories, flagging clean completion (done) or malformed framing (err).
module ledpanel_loader
  import ledpanel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WR_W   = WR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ctrl_en,
  output logic [WR_W-1:0]   ctrl_wr,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [23:0]       ctrl_wdat,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic [7:0]        hi_byte, r_byte, g_byte;
  logic [ADDR_W-1:0] addr, count, count_dec, hdr_word;
  logic              fire_wr, fire_done, fire_err;

  assign s_ready   = !reset;
  assign busy      = (state != HDR_SEL);
  assign hdr_word  = ADDR_W'({hi_byte, s_data});
  assign count_dec = count - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= HDR_SEL;
    else       state <= state_nxt;
  end

  // An s_last seen before the packet is complete always aborts back to HDR_SEL with err.
  always_comb begin
    state_nxt = state;
    fire_wr   = 1'b0;
    fire_done = 1'b0;
    fire_err  = 1'b0;
    if (s_valid) begin
      case (state)
        HDR_SEL: begin
          if (s_data[7:2] != 6'd0) begin
            fire_err  = 1'b1;
            state_nxt = s_last ? HDR_SEL : DRAIN;
          end else begin
            fire_err  = s_last;
            state_nxt = s_last ? HDR_SEL : HDR_AH;
          end
        end
        HDR_AH: begin
          fire_err  = s_last;
          state_nxt = s_last ? HDR_SEL : HDR_AL;
        end
        HDR_AL: begin
          fire_err  = s_last;
          state_nxt = s_last ? HDR_SEL : HDR_NH;
        end
        HDR_NH: begin
          fire_err  = s_last;
          state_nxt = s_last ? HDR_SEL : HDR_NL;
        end
        HDR_NL: begin
          if (hdr_word == '0) begin
            fire_done = s_last;
            fire_err  = !s_last;
            state_nxt = s_last ? HDR_SEL : DRAIN;
          end else begin
            fire_err  = s_last;
            state_nxt = s_last ? HDR_SEL : PIX_R;
          end
        end
        PIX_R: begin
          fire_err  = s_last;
          state_nxt = s_last ? HDR_SEL : PIX_G;
        end
        PIX_G: begin
          fire_err  = s_last;
          state_nxt = s_last ? HDR_SEL : PIX_B;
        end
        PIX_B: begin
          fire_wr = 1'b1;
          if (count_dec == '0) begin
            fire_done = s_last;
            fire_err  = !s_last;
            state_nxt = s_last ? HDR_SEL : DRAIN;
          end else begin
            fire_err  = s_last;
            state_nxt = s_last ? HDR_SEL : PIX_R;
          end
        end
        DRAIN: begin
          if (s_last) state_nxt = HDR_SEL;
        end
        default: state_nxt = HDR_SEL;
      endcase
    end
  end

  // Write port is registered, so a pixel lands one cycle after its B byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ctrl_wr   <= '0;
      ctrl_addr <= '0;
      ctrl_wdat <= '0;
      hi_byte   <= '0;
      r_byte    <= '0;
      g_byte    <= '0;
      addr      <= '0;
      count     <= '0;
    end else begin
      ctrl_en <= fire_wr;
      done    <= fire_done;
      err     <= fire_err;
      if (fire_wr) begin
        ctrl_addr <= addr;
        ctrl_wdat <= {r_byte, g_byte, s_data};
        addr      <= addr + ADDR_W'(1);
        count     <= count_dec;
      end
      if (s_valid) begin
        case (state)
          HDR_SEL:        ctrl_wr <= WR_W'(1) << s_data[1:0];
          HDR_AH, HDR_NH: hi_byte <= s_data;
          HDR_AL:         addr    <= hdr_word;
          HDR_NL:         count   <= hdr_word;
          PIX_R:          r_byte  <= s_data;
          PIX_G:          g_byte  <= s_data;
          default:        ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ledpanel_loader.sv
// Randomized bench for ledpanel_loader: every packet is also fed to a packet-level
// reference model, and the recorded write/event streams are compared at the end.
module tb_ledpanel_loader;

  localparam logic [7:0] EV_DONE = 8'h44;
  localparam logic [7:0] EV_ERR  = 8'h45;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [3:0]  wr;
    logic [15:0] addr;
    logic [23:0] data;
    logic        fin;
  } wrec_t;

  typedef logic [7:0] pkt_t[$];

  wrec_t      exp_w[$], got_w[$];
  logic [7:0] exp_ev[$], got_ev[$];
  int         n_compared = 0;
  int         n_mismatched = 0;
  int         both_cnt = 0;

  ledpanel_loader #(.ADDR_W(16), .WR_W(4)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ctrl_en === 1'b1) got_w.push_back('{ctrl_wr, ctrl_addr, ctrl_wdat, done === 1'b1});
    if (done === 1'b1) got_ev.push_back(EV_DONE);
    if (err === 1'b1) got_ev.push_back(EV_ERR);
    if (done === 1'b1 && err === 1'b1) both_cnt++;
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet-level outcome: complete pixels (up to CNT) are written, exactly one
  // done/err per packet, done only when the length is exactly 5 + 3*CNT.
  function automatic void model_packet(input pkt_t p, input bit aborted);
    int          n;
    int          full;
    int          nw;
    logic [15:0] a;
    logic [15:0] c;
    logic [3:0]  wr;
    bit          clean;
    n = p.size();
    if (n == 0) return;
    wr = 4'b0001 << p[0][1:0];
    if (p[0][7:2] != 6'd0 || n < 5) begin
      if (!aborted) exp_ev.push_back(EV_ERR);
      return;
    end
    a = {p[1], p[2]};
    c = {p[3], p[4]};
    clean = !aborted && (n == 5 + 3 * int'(c));
    full = (n - 5) / 3;
    nw = (full < int'(c)) ? full : int'(c);
    for (int i = 0; i < nw; i++)
      exp_w.push_back('{wr, a + 16'(i), {p[5+3*i], p[6+3*i], p[7+3*i]}, clean && (i == nw - 1)});
    if (!aborted) exp_ev.push_back(clean ? EV_DONE : EV_ERR);
  endfunction

  function automatic pkt_t make_packet(input logic [7:0] sel, input logic [15:0] addr,
                                       input int cnt, input int len);
    pkt_t p;
    p.push_back(sel);
    p.push_back(addr[15:8]);
    p.push_back(addr[7:0]);
    p.push_back(8'(cnt >> 8));
    p.push_back(8'(cnt));
    while (p.size() < len) p.push_back(8'($urandom));
    while (p.size() > len) void'(p.pop_back());
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit last, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic apply_stimulus(input pkt_t p, input bit gaps);
    model_packet(p, 1'b0);
    for (int i = 0; i < p.size(); i++) send_byte(p[i], i == p.size() - 1, gaps);
  endtask

  task automatic check_reset_values(input string pfx);
    check_output({pfx, "_ctrl_en"},   64'(ctrl_en),   64'd0);
    check_output({pfx, "_ctrl_wr"},   64'(ctrl_wr),   64'd0);
    check_output({pfx, "_ctrl_addr"}, 64'(ctrl_addr), 64'd0);
    check_output({pfx, "_ctrl_wdat"}, 64'(ctrl_wdat), 64'd0);
    check_output({pfx, "_busy"},      64'(busy),      64'd0);
    check_output({pfx, "_done"},      64'(done),      64'd0);
    check_output({pfx, "_err"},       64'(err),       64'd0);
    check_output({pfx, "_s_ready"},   64'(s_ready),   64'd0);
  endtask

  initial begin
    pkt_t p;
    int   cnt, full, len, kind, nmin;
    logic [7:0]  sel;
    logic [15:0] addr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_output("s_ready_after_rst", 64'(s_ready), 64'd1);

    // Basic two-pixel write to block 2
    apply_stimulus('{8'h02, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
    // Address wrap at top of range
    apply_stimulus('{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3}, 1'b1);
    // Invalid SEL drained, then a valid packet
    apply_stimulus('{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0);
    apply_stimulus('{8'h01, 8'h20, 8'h00, 8'h00, 8'h01, 8'hC1, 8'hC2, 8'hC3}, 1'b0);
    // Early s_last on a G byte
    apply_stimulus('{8'h01, 8'h30, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0);
    check_output("early_last_busy", 64'(busy), 64'd0);
    check_output("early_last_err",  64'(err),  64'd1);
    // Zero count, and a too-long packet drained to resync
    apply_stimulus('{8'h03, 8'h40, 8'h00, 8'h00, 8'h00}, 1'b0);
    apply_stimulus('{8'h03, 8'h50, 8'h00, 8'h00, 8'h01, 8'hD1, 8'hD2, 8'hD3,
                     8'hE0, 8'hE1, 8'hE2, 8'hE3}, 1'b0);

    // Reset in PIX_G of the second pixel: first pixel stands, no event
    p = '{8'h03, 8'h12, 8'h34, 8'h00, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    model_packet(p, 1'b1);
    for (int i = 0; i < p.size(); i++) send_byte(p[i], 1'b0, 1'b1);
    check_output("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_values("midrst");
    reset = 1'b0;
    apply_stimulus('{8'h02, 8'h60, 8'h00, 8'h00, 8'h01, 8'hF1, 8'hF2, 8'hF3}, 1'b1);

    for (int k = 0; k < 40; k++) begin
      cnt  = $urandom_range(0, 4);
      full = 5 + 3 * cnt;
      kind = $urandom_range(0, 9);
      sel  = {6'd0, 2'($urandom)};
      if (kind == 9) sel[7:2] = 6'($urandom_range(1, 63));
      len = full;
      if (kind == 7) len = $urandom_range(1, full);
      if (kind == 8) len = full + $urandom_range(1, 4);
      addr = kind[0] ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      apply_stimulus(make_packet(sel, addr, cnt, len), 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    check_output("write_count", 64'(got_w.size()), 64'(exp_w.size()));
    nmin = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < nmin; i++)
      check_output($sformatf("write[%0d]", i), 64'(got_w[i]), 64'(exp_w[i]));
    check_output("event_count", 64'(got_ev.size()), 64'(exp_ev.size()));
    nmin = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
    for (int i = 0; i < nmin; i++)
      check_output($sformatf("event[%0d]", i), 64'(got_ev[i]), 64'(exp_ev[i]));
    check_output("done_and_err_together", 64'(both_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
